// File: rtl/pbuf_rd_scheduler.sv
// Path-buffer read scheduler: shares one read port between the Enc and Hash feeds with credits.
// Define PBUF_SCHED_ENC_PRIO_EN to give Enc fixed priority instead of round-robin arbitration.

module pbuf_rd_req #(
  parameter int AWidth     = 6,
  parameter int MaxCredits = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [AWidth-1:0] i_base,
  input  logic [AWidth-1:0] i_len,
  input  logic              i_creditRet,
  input  logic              i_grant,
  output logic              o_eligible,
  output logic [AWidth-1:0] o_addr,
  output logic              o_dataValid,
  output logic              o_done,
  output logic              o_busy
);

  localparam int CW = $clog2(MaxCredits + 1);

  // ZLEN holds a zero-length job for one cycle so Done keeps its two-cycle latency from Start.
  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_ZLEN, S_DONE} state_t;

  state_t            r_state;
  logic [AWidth-1:0] r_addr;
  logic [AWidth-1:0] r_rem;
  logic [CW-1:0]     r_credits;
  logic              r_dataValid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_credits   <= CW'(MaxCredits);
      r_dataValid <= 1'b0;
    end else begin
      r_dataValid <= i_grant;
      if (i_grant && !i_creditRet)
        r_credits <= r_credits - 1'b1;
      else if (!i_grant && i_creditRet && r_credits != CW'(MaxCredits))
        r_credits <= r_credits + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              r_state <= S_ACTIVE;
              r_addr  <= i_base;
              r_rem   <= i_len;
            end else begin
              r_state <= S_ZLEN;
            end
          end
        end
        S_ACTIVE: begin
          if (i_grant) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == AWidth'(1))
              r_state <= S_DRAIN;
          end
        end
        // The last word is always in flight for exactly one cycle after the final grant.
        S_DRAIN: r_state <= S_DONE;
        S_ZLEN:  r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_eligible  = (r_state == S_ACTIVE) && (r_credits != '0);
  assign o_addr      = r_addr;
  assign o_dataValid = r_dataValid;
  assign o_done      = (r_state == S_DONE);
  assign o_busy      = (r_state == S_ACTIVE) || (r_state == S_DRAIN);

endmodule

module pbuf_rd_scheduler #(
  parameter int DWidth     = 512,
  parameter int AWidth     = 6,
  parameter int MaxCredits = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_encStart,
  input  logic [AWidth-1:0] i_encBase,
  input  logic [AWidth-1:0] i_encLen,
  input  logic              i_encCreditRet,
  output logic              o_encDataValid,
  output logic              o_encDone,
  input  logic              i_hashStart,
  input  logic [AWidth-1:0] i_hashBase,
  input  logic [AWidth-1:0] i_hashLen,
  input  logic              i_hashCreditRet,
  output logic              o_hashDataValid,
  output logic              o_hashDone,
  output logic              o_bufEnable,
  output logic [AWidth-1:0] o_bufAddress,
  input  logic [DWidth-1:0] i_bufDOut,
  output logic [DWidth-1:0] o_dataOut,
  output logic              o_busy
);

  logic              w_encElig, w_hashElig;
  logic              w_encGrant, w_hashGrant;
  logic [AWidth-1:0] w_encAddr, w_hashAddr;
  logic              w_encBusy, w_hashBusy;

  pbuf_rd_req #(.AWidth(AWidth), .MaxCredits(MaxCredits)) u_enc (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_encStart), .i_base(i_encBase),
    .i_len(i_encLen), .i_creditRet(i_encCreditRet), .i_grant(w_encGrant),
    .o_eligible(w_encElig), .o_addr(w_encAddr), .o_dataValid(o_encDataValid),
    .o_done(o_encDone), .o_busy(w_encBusy)
  );

  pbuf_rd_req #(.AWidth(AWidth), .MaxCredits(MaxCredits)) u_hash (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_hashStart), .i_base(i_hashBase),
    .i_len(i_hashLen), .i_creditRet(i_hashCreditRet), .i_grant(w_hashGrant),
    .o_eligible(w_hashElig), .o_addr(w_hashAddr), .o_dataValid(o_hashDataValid),
    .o_done(o_hashDone), .o_busy(w_hashBusy)
  );

`ifdef PBUF_SCHED_ENC_PRIO_EN
  assign w_encGrant  = w_encElig;
  assign w_hashGrant = w_hashElig && !w_encElig;
`else
  // Pointer only moves on contention: 0 favours Enc, 1 favours Hash.
  logic r_rrPtr;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_rrPtr <= 1'b0;
    else if (w_encElig && w_hashElig)
      r_rrPtr <= ~r_rrPtr;
  end

  assign w_encGrant  = w_encElig && (!w_hashElig || !r_rrPtr);
  assign w_hashGrant = w_hashElig && (!w_encElig || r_rrPtr);
`endif

  assign o_bufEnable  = w_encGrant || w_hashGrant;
  assign o_bufAddress = w_encGrant ? w_encAddr : (w_hashGrant ? w_hashAddr : '0);
  assign o_dataOut    = i_bufDOut;
  assign o_busy       = w_encBusy || w_hashBusy;

endmodule

// File: tb/tb_pbuf_rd_scheduler.sv
// Directed bench for pbuf_rd_scheduler; expectations are hand-derived cycle tables.
// Honours PBUF_SCHED_ENC_PRIO_EN for the both-active grant order.

module tb_pbuf_rd_scheduler;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_encStart, i_hashStart;
  logic [5:0]   i_encBase, i_encLen, i_hashBase, i_hashLen;
  logic         i_encCreditRet, i_hashCreditRet;
  logic         o_encDataValid, o_encDone, o_hashDataValid, o_hashDone;
  logic         o_bufEnable;
  logic [5:0]   o_bufAddress;
  logic [511:0] i_bufDOut;
  logic [511:0] o_dataOut;
  logic         o_busy;

  int vecCount  = 0;
  int missCount = 0;

  pbuf_rd_scheduler dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_encStart(i_encStart), .i_encBase(i_encBase), .i_encLen(i_encLen),
    .i_encCreditRet(i_encCreditRet), .o_encDataValid(o_encDataValid), .o_encDone(o_encDone),
    .i_hashStart(i_hashStart), .i_hashBase(i_hashBase), .i_hashLen(i_hashLen),
    .i_hashCreditRet(i_hashCreditRet), .o_hashDataValid(o_hashDataValid), .o_hashDone(o_hashDone),
    .o_bufEnable(o_bufEnable), .o_bufAddress(o_bufAddress),
    .i_bufDOut(i_bufDOut), .o_dataOut(o_dataOut), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  // Checks one cycle's outputs after inputs settle, then advances to the next cycle.
  task automatic applyStimulus(input string tag, input logic en, input logic [5:0] addr,
                               input logic ev, input logic hv, input logic ed,
                               input logic hd, input logic busy);
    #1;
    checkOutput({tag, ".en"}, 512'(o_bufEnable), 512'(en));
    if (en) checkOutput({tag, ".addr"}, 512'(o_bufAddress), 512'(addr));
    checkOutput({tag, ".ev"}, 512'(o_encDataValid), 512'(ev));
    checkOutput({tag, ".hv"}, 512'(o_hashDataValid), 512'(hv));
    checkOutput({tag, ".ed"}, 512'(o_encDone), 512'(ed));
    checkOutput({tag, ".hd"}, 512'(o_hashDone), 512'(hd));
    checkOutput({tag, ".busy"}, 512'(o_busy), 512'(busy));
    nextCycle();
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    nextCycle();
    i_reset = 1'b0;
  endtask

  logic [5:0]   seqAddr [8];
  logic         seqEnc  [8];
  logic [511:0] expData;
  int           lastE;

  initial begin
    i_reset = 1'b1;
    i_encStart = 1'b0;  i_encBase = '0;  i_encLen = '0;  i_encCreditRet = 1'b0;
    i_hashStart = 1'b0; i_hashBase = '0; i_hashLen = '0; i_hashCreditRet = 1'b0;
    expData = {16{$urandom}};
    i_bufDOut = expData;
    nextCycle();
    nextCycle();

    applyStimulus("rst", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst.addr", 512'(o_bufAddress), 512'(0));
    checkOutput("rst.dout", o_dataOut, expData);
    i_reset = 1'b0;

    // Enc-only, credits returned on each data cycle
    i_encStart = 1; i_encBase = 6'd8; i_encLen = 6'd3;
    applyStimulus("a0", 0, 0, 0, 0, 0, 0, 0);
    i_encStart = 0;
    applyStimulus("a1", 1, 8, 0, 0, 0, 0, 1);
    i_encCreditRet = 1;
    applyStimulus("a2", 1, 9, 1, 0, 0, 0, 1);
    applyStimulus("a3", 1, 10, 1, 0, 0, 0, 1);
    applyStimulus("a4", 0, 0, 1, 0, 0, 0, 1);
    i_encCreditRet = 0;
    applyStimulus("a5", 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("a6", 0, 0, 0, 0, 0, 0, 0);

    // Both requesters active, credits held full by constant returns
`ifdef PBUF_SCHED_ENC_PRIO_EN
    seqEnc  = '{1, 1, 1, 1, 0, 0, 0, 0};
    seqAddr = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd32, 6'd33, 6'd34, 6'd35};
`else
    seqEnc  = '{1, 0, 1, 0, 1, 0, 1, 0};
    seqAddr = '{6'd0, 6'd32, 6'd1, 6'd33, 6'd2, 6'd34, 6'd3, 6'd35};
`endif
    lastE = 0;
    for (int i = 0; i < 8; i++) if (seqEnc[i]) lastE = i + 1;
    doReset();
    i_encStart = 1; i_encBase = 6'd0; i_encLen = 6'd4;
    i_hashStart = 1; i_hashBase = 6'd32; i_hashLen = 6'd4;
    i_encCreditRet = 1; i_hashCreditRet = 1;
    applyStimulus("b0", 0, 0, 0, 0, 0, 0, 0);
    i_encStart = 0; i_hashStart = 0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus($sformatf("b%0d", k),
                    k <= 8, (k <= 8) ? seqAddr[k-1] : 6'd0,
                    (k >= 2 && k <= 9) ? seqEnc[k-2] : 1'b0,
                    (k >= 2 && k <= 9) ? !seqEnc[k-2] : 1'b0,
                    k == lastE + 2, k == 10, k <= 9);
    end
    i_encCreditRet = 0; i_hashCreditRet = 0;

    // Credit exhaustion: two grants, stall, one return buys one more grant
    doReset();
    i_encStart = 1; i_encBase = 6'd16; i_encLen = 6'd5;
    applyStimulus("c0", 0, 0, 0, 0, 0, 0, 0);
    i_encStart = 0;
    applyStimulus("c1", 1, 16, 0, 0, 0, 0, 1);
    applyStimulus("c2", 1, 17, 1, 0, 0, 0, 1);
    applyStimulus("c3", 0, 0, 1, 0, 0, 0, 1);
    i_encCreditRet = 1;
    applyStimulus("c4", 0, 0, 0, 0, 0, 0, 1);
    i_encCreditRet = 0;
    applyStimulus("c5", 1, 18, 0, 0, 0, 0, 1);
    applyStimulus("c6", 0, 0, 1, 0, 0, 0, 1);
    applyStimulus("c7", 0, 0, 0, 0, 0, 0, 1);

    // Zero-length Hash job
    doReset();
    i_hashStart = 1; i_hashBase = 6'd3; i_hashLen = 6'd0;
    applyStimulus("d0", 0, 0, 0, 0, 0, 0, 0);
    i_hashStart = 0;
    applyStimulus("d1", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("d2", 0, 0, 0, 0, 0, 1, 0);
    applyStimulus("d3", 0, 0, 0, 0, 0, 0, 0);

    // Address wrap at the top of the buffer
    doReset();
    i_encStart = 1; i_encBase = 6'd62; i_encLen = 6'd4; i_encCreditRet = 1;
    applyStimulus("e0", 0, 0, 0, 0, 0, 0, 0);
    i_encStart = 0;
    applyStimulus("e1", 1, 62, 0, 0, 0, 0, 1);
    applyStimulus("e2", 1, 63, 1, 0, 0, 0, 1);
    applyStimulus("e3", 1, 0, 1, 0, 0, 0, 1);
    applyStimulus("e4", 1, 1, 1, 0, 0, 0, 1);
    applyStimulus("e5", 0, 0, 1, 0, 0, 0, 1);
    applyStimulus("e6", 0, 0, 0, 0, 1, 0, 0);
    i_encCreditRet = 0;

    // Reset mid-job abandons it and restores credits
    doReset();
    i_encStart = 1; i_encBase = 6'd4; i_encLen = 6'd4;
    applyStimulus("f0", 0, 0, 0, 0, 0, 0, 0);
    i_encStart = 0;
    applyStimulus("f1", 1, 4, 0, 0, 0, 0, 1);
    applyStimulus("f2", 1, 5, 1, 0, 0, 0, 1);
    i_reset = 1;
    applyStimulus("f3", 0, 0, 1, 0, 0, 0, 1);
    i_reset = 0;
    applyStimulus("f4", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("f5", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("f6", 0, 0, 0, 0, 0, 0, 0);
    i_encStart = 1; i_encBase = 6'd0; i_encLen = 6'd3;
    expData = {16{$urandom}};
    i_bufDOut = expData;
    applyStimulus("f7", 0, 0, 0, 0, 0, 0, 0);
    i_encStart = 0;
    applyStimulus("f8", 1, 0, 0, 0, 0, 0, 1);
    applyStimulus("f9", 1, 1, 1, 0, 0, 0, 1);
    applyStimulus("f10", 0, 0, 1, 0, 0, 0, 1);
    checkOutput("f.dout", o_dataOut, expData);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
